spi_aes_frame_slave: RTL and testbench

- Parametrised SPI slave front-end for the AES cipher core; successor to the fixed-key-length encrypt-only SPI slave.
- Accepts a framed transaction: command byte, 128-bit block, then 32*NK-bit key.
- Starts an external encrypt/decrypt core through a start/done handshake, then returns the 128-bit result on MISO behind a ready marker.
- All SPI pins are oversampled on the system clock.

---
 rtl/spi_aes_frame_slave.sv | 252 +++++++++++++++++++++++++
 tb/tb_spi_aes_frame_slave.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_aes_frame_slave.sv
// spi_aes_frame_slave: SPI mode-0 slave front-end for an external AES core.
// Frame = command byte, 128-bit block, 32*NK-bit key (all MSB first); the core
// is started with a one-cycle pulse and its result is returned on MISO behind
// a '1' ready marker. All SPI pins are oversampled on clk.
// Optional feature macro: SPI_AES_KEY_RETAIN_EN (keep key across frames,
// command bit6 reuses it and skips the key phase).
module spi_aes_frame_slave #(
    parameter int NK          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              core_start,
    output logic              core_mode,
    output logic [127:0]      core_block,
    output logic [32*NK-1:0]  core_key,
    input  logic [127:0]      core_result,
    input  logic              core_done,
    output logic              busy,
    output logic              frame_err
);
    localparam int KW = 32 * NK;
    localparam int CW = $clog2(KW + 129);
    localparam logic [CW-1:0] CMD_LAST  = CW'(7);
    localparam logic [CW-1:0] DATA_LAST = CW'(127);
    localparam logic [CW-1:0] KEY_LAST  = CW'(KW - 1);
    localparam logic [CW-1:0] TX_BITS   = CW'(128);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_DATA, S_KEY, S_WAIT, S_TX, S_END
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_s, cs_s, mosi_s, sclk_d;
    logic                   sclk_rise, sclk_fall;
    logic [CW-1:0]          cnt;
    logic [6:0]             cmd_sh;
    logic [7:0]             cmd_full;
    logic [127:0]           block_q, result_q;
    logic [KW-1:0]          key_q;
    logic                   mode_q, marker_q;
    logic                   err_nxt, start_nxt, abort;
    logic                   cmd_bad, reuse, done_ok;
`ifdef SPI_AES_KEY_RETAIN_EN
    logic                   key_valid, reuse_q;
`endif

    // Input synchronisers; cs_n idles high, so its chain resets to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_d;
    assign sclk_fall  = ~sclk_s & sclk_d;
    assign cmd_full   = {cmd_sh, mosi_s};
    // A done in the start cycle cannot be a real answer for this block.
    assign done_ok    = core_done & ~core_start;

`ifdef SPI_AES_KEY_RETAIN_EN
    assign cmd_bad = (|cmd_full[5:0]) | (cmd_full[6] & ~key_valid);
    assign reuse   = reuse_q;
`else
    assign cmd_bad = (|cmd_full[5:0]) | cmd_full[6];
    assign reuse   = 1'b0;
`endif

    assign busy       = (state != S_IDLE);
    assign core_mode  = mode_q;
    assign core_block = block_q;
    assign core_key   = key_q;

    // State register and the registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            core_start <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            core_start <= start_nxt;
            frame_err  <= err_nxt;
        end
    end

    // Next-state logic; a cs_n release mid-frame overrides everything.
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        start_nxt = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: if (!cs_s) state_nxt = S_CMD;
            S_CMD: begin
                if (sclk_rise && cnt == CMD_LAST) begin
                    if (cmd_bad) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_END;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (sclk_rise && cnt == DATA_LAST) begin
                    if (reuse) begin
                        start_nxt = 1'b1;
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = S_KEY;
                    end
                end
            end
            S_KEY: begin
                if (sclk_rise && cnt == KEY_LAST) begin
                    start_nxt = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (done_ok) state_nxt = S_TX;
            S_TX: if (sclk_fall && marker_q && cnt == TX_BITS) state_nxt = S_END;
            S_END: if (cs_s) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (cs_s && (state inside {S_CMD, S_DATA, S_KEY, S_WAIT, S_TX})) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
            start_nxt = 1'b0;
            abort     = 1'b1;
        end
    end

    // Shift registers, bit counter and MISO driver.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            cmd_sh   <= '0;
            block_q  <= '0;
            key_q    <= '0;
            result_q <= '0;
            mode_q   <= 1'b0;
            marker_q <= 1'b0;
            miso     <= 1'b0;
`ifdef SPI_AES_KEY_RETAIN_EN
            key_valid <= 1'b0;
            reuse_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cnt      <= '0;
                    cmd_sh   <= '0;
                    block_q  <= '0;
                    result_q <= '0;
                    mode_q   <= 1'b0;
                    marker_q <= 1'b0;
                    miso     <= 1'b0;
`ifdef SPI_AES_KEY_RETAIN_EN
                    reuse_q  <= 1'b0;
`else
                    key_q    <= '0;
`endif
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        cmd_sh <= cmd_full[6:0];
                        cnt    <= (cnt == CMD_LAST) ? '0 : cnt + CW'(1);
                        if (cnt == CMD_LAST) begin
                            mode_q  <= cmd_full[7];
`ifdef SPI_AES_KEY_RETAIN_EN
                            reuse_q <= cmd_full[6];
`endif
                        end
                    end
                end
                S_DATA: begin
                    if (sclk_rise) begin
                        block_q <= {block_q[126:0], mosi_s};
                        cnt     <= (cnt == DATA_LAST) ? '0 : cnt + CW'(1);
                    end
                end
                S_KEY: begin
                    if (sclk_rise) begin
                        key_q <= {key_q[KW-2:0], mosi_s};
                        cnt   <= (cnt == KEY_LAST) ? '0 : cnt + CW'(1);
`ifdef SPI_AES_KEY_RETAIN_EN
                        if (cnt == KEY_LAST) key_valid <= 1'b1;
`endif
                    end
                end
                S_WAIT: begin
                    miso <= 1'b0;
                    if (done_ok) begin
                        result_q <= core_result;
                        cnt      <= '0;
                        marker_q <= 1'b0;
                    end
                end
                S_TX: begin
                    // Marker first, then 128 result bits, then drive low.
                    if (sclk_fall) begin
                        if (!marker_q) begin
                            miso     <= 1'b1;
                            marker_q <= 1'b1;
                        end else if (cnt == TX_BITS) begin
                            miso <= 1'b0;
                        end else begin
                            miso     <= result_q[127];
                            result_q <= {result_q[126:0], 1'b0};
                            cnt      <= cnt + CW'(1);
                        end
                    end
                end
                S_END: miso <= 1'b0;
                default: ;
            endcase
            if (abort) begin
                cnt      <= '0;
                cmd_sh   <= '0;
                block_q  <= '0;
                key_q    <= '0;
                result_q <= '0;
                mode_q   <= 1'b0;
                marker_q <= 1'b0;
                miso     <= 1'b0;
`ifdef SPI_AES_KEY_RETAIN_EN
                key_valid <= 1'b0;
                reuse_q   <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_spi_aes_frame_slave.sv
// Bench for spi_aes_frame_slave: NK=4 and NK=8 instances, a stub AES core per
// instance, a table of fixed frames, hand-written abort/zero-latency sequences
// and randomized frames checked against a frame-level model.
module tb_spi_aes_frame_slave;
    localparam int HALF = 5;
`ifdef SPI_AES_KEY_RETAIN_EN
    localparam bit RETAIN = 1'b1;
`else
    localparam bit RETAIN = 1'b0;
`endif
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128L = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0, rst = 1'b0;
    logic sclk = 1'b0, mosi = 1'b0, cs4_n = 1'b1, cs8_n = 1'b1;
    logic miso4, miso8, st4, st8, md4, md8, busy4, busy8, err4, err8;
    logic done4, done8, done4_r = 1'b0;
    logic [127:0] blk4, blk8, res4, res8, res4_r = '0;
    logic [127:0] key4;
    logic [255:0] key8;

    int nvec = 0, nmis = 0, cur = 0, lat = 20;
    bit zero_inj = 1'b0;
    bit kloaded [2];
    logic [255:0] kstore [2];

    // stub core state (one set per instance)
    int nst4 = 0, ner4 = 0, cd4 = 0, nst8 = 0, ner8 = 0, cd8 = 0;
    logic [127:0] cb4 = '0, cb8 = '0;
    logic [255:0] ck4 = '0, ck8 = '0;
    logic cm4 = 1'b0, cm8 = 1'b0, dm4 = 1'b0, dm8 = 1'b0;

    always #5 clk = ~clk;

    spi_aes_frame_slave #(.NK(4), .SYNC_STAGES(2)) u_dut4 (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs4_n), .mosi(mosi), .miso(miso4),
        .core_start(st4), .core_mode(md4), .core_block(blk4), .core_key(key4),
        .core_result(res4), .core_done(done4), .busy(busy4), .frame_err(err4)
    );

    spi_aes_frame_slave #(.NK(8), .SYNC_STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs8_n), .mosi(mosi), .miso(miso8),
        .core_start(st8), .core_mode(md8), .core_block(blk8), .core_key(key8),
        .core_result(res8), .core_done(done8), .busy(busy8), .frame_err(err8)
    );

    // Stub cipher: real FIPS answers for the two known vectors, a cheap mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] b, input logic [255:0] k, input logic m);
        if (!m && b == PT && k == K128L) return CT128;
        if (m && b == CT256 && k == K256) return PT;
        return {b[63:0], b[127:64]} ^ k[255:128] ^ k[127:0] ^ {128{m}};
    endfunction

    // NK=4 stub core; zero_inj also fires a bogus done in the start cycle.
    always @(posedge clk) begin
        done4_r <= 1'b0;
        if (err4) ner4 <= ner4 + 1;
        if (st4) begin
            nst4 <= nst4 + 1; cb4 <= blk4; ck4 <= {key4, 128'h0}; cm4 <= md4; cd4 <= lat;
        end else if (cd4 > 0) begin
            cd4 <= cd4 - 1;
            if (cd4 == 1) begin done4_r <= 1'b1; res4_r <= core_fn(cb4, ck4, cm4); dm4 <= md4; end
        end
    end
    assign done4 = done4_r | (zero_inj & st4);
    assign res4  = (zero_inj & st4) ? ~128'h0 : res4_r;

    // NK=8 stub core.
    always @(posedge clk) begin
        done8 <= 1'b0;
        if (err8) ner8 <= ner8 + 1;
        if (st8) begin
            nst8 <= nst8 + 1; cb8 <= blk8; ck8 <= key8; cm8 <= md8; cd8 <= lat;
        end else if (cd8 > 0) begin
            cd8 <= cd8 - 1;
            if (cd8 == 1) begin done8 <= 1'b1; res8 <= core_fn(cb8, ck8, cm8); dm8 <= md8; end
        end
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int n_st(input int d); return d ? nst8 : nst4; endfunction
    function automatic int n_er(input int d); return d ? ner8 : ner4; endfunction
    function automatic logic busy_of(input int d); return d ? busy8 : busy4; endfunction

    task automatic cs_set(input int d, input logic v);
        if (d != 0) cs8_n = v; else cs4_n = v;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic sclk_cycle(input logic b, output logic s);
        mosi = b;
        repeat (HALF) @(posedge clk);
        #1;
        s = (cur != 0) ? miso8 : miso4;
        sclk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [255:0] v, input int n);
        logic s;
        for (int i = 0; i < n; i++) sclk_cycle(v[255-i], s);
    endtask

    // Poll for the ready marker, read 128 bits, then clock two spare cycles.
    task automatic receive(output logic [127:0] rx, output bit ok);
        logic s;
        int n;
        ok = 1'b0; rx = '0; n = 0;
        while (!ok && n < 60) begin
            sclk_cycle(1'b0, s);
            if (s === 1'b1) ok = 1'b1;
            n++;
        end
        if (ok) begin
            for (int i = 0; i < 128; i++) begin
                sclk_cycle(1'b0, s);
                rx = {rx[126:0], s};
            end
            for (int i = 0; i < 2; i++) begin
                sclk_cycle(1'b0, s);
                check("end_miso_low", 256'(s), 256'(0));
            end
        end
    endtask

    task automatic do_frame(input int d, input logic [7:0] cmd, input logic [127:0] blk,
                            input logic [255:0] key, input bit exp_err, input logic [127:0] exp_res);
        logic [127:0] rx;
        logic [255:0] ekey;
        bit ok;
        int s0, e0;
        ekey = cmd[6] ? kstore[d] : key;
        s0 = n_st(d); e0 = n_er(d); cur = d;
        cs_set(d, 1'b0);
        send_bits({cmd, 248'h0}, 8);
        if (exp_err) begin
            repeat (6) @(posedge clk);
            #1;
            check("cmd_err_pulse", 256'(n_er(d) - e0), 256'(1));
            check("cmd_err_busy", 256'(busy_of(d)), 256'(1));
            cs_set(d, 1'b1);
            check("cmd_err_busy_drop", 256'(busy_of(d)), 256'(0));
            check("cmd_err_no_start", 256'(n_st(d) - s0), 256'(0));
        end else begin
            send_bits({blk, 128'h0}, 128);
            if (!cmd[6]) send_bits(key, d ? 256 : 128);
            receive(rx, ok);
            check("ready_marker", 256'(ok), 256'(1));
            check("result", 256'(rx), 256'(exp_res));
            check("start_once", 256'(n_st(d) - s0), 256'(1));
            check("core_block", 256'(d ? cb8 : cb4), 256'(blk));
            check("core_key", d ? ck8 : ck4, ekey);
            check("core_mode_start", 256'(d ? cm8 : cm4), 256'(cmd[7]));
            check("core_mode_done", 256'(d ? dm8 : dm4), 256'(cmd[7]));
            check("no_err", 256'(n_er(d) - e0), 256'(0));
            cs_set(d, 1'b1);
            check("busy_drop", 256'(busy_of(d)), 256'(0));
            if (!cmd[6]) begin kloaded[d] = 1'b1; kstore[d] = key; end
        end
    endtask

    typedef struct {
        int           d;
        logic [7:0]   cmd;
        logic [127:0] blk;
        logic [255:0] key;
        bit           err;
        logic [127:0] res;
    } vec_t;

    initial begin
        vec_t tbl [6];
        logic [127:0] b1, b2, blk;
        logic [255:0] key, ekey;
        logic [7:0] cmd;
        int s0, e0, d;
        bit err;

        b1 = 128'hfeedface_01234567_89abcdef_0badc0de;
        b2 = 128'h13579bdf_2468ace0_deadbeef_cafef00d;
        tbl[0] = '{1, 8'h40, b1, '0, 1'b1, '0};
        tbl[1] = '{0, 8'h00, PT, K128L, 1'b0, CT128};
        tbl[2] = '{1, 8'h80, CT256, K256, 1'b0, PT};
        tbl[3] = '{0, 8'h21, b1, K128L, 1'b1, '0};
        tbl[4] = '{0, 8'h40, b1, '0, !RETAIN, core_fn(b1, K128L, 1'b0)};
        tbl[5] = '{1, 8'hc0, b2, '0, !RETAIN, core_fn(b2, K256, 1'b1)};
        kloaded[0] = 1'b0; kloaded[1] = 1'b0;
        kstore[0] = '0; kstore[1] = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_miso", 256'({miso4, miso8}), 256'(0));
        check("rst_busy", 256'({busy4, busy8}), 256'(0));
        check("rst_start", 256'({st4, st8}), 256'(0));
        check("rst_err", 256'({err4, err8}), 256'(0));
        check("rst_mode", 256'({md4, md8}), 256'(0));
        check("rst_regs", 256'(blk4 | blk8 | key4 | key8[127:0] | key8[255:128]), 256'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", 256'({busy4, busy8}), 256'(0));

        for (int i = 0; i < 6; i++)
            do_frame(tbl[i].d, tbl[i].cmd, tbl[i].blk, tbl[i].key, tbl[i].err, tbl[i].res);

        // abort after 70 data bits, then a clean frame
        cur = 0; s0 = nst4; e0 = ner4;
        cs_set(0, 1'b0);
        send_bits(256'h0, 8);
        send_bits({b2, 128'h0}, 70);
        cs_set(0, 1'b1);
        check("abort70_err", 256'(ner4 - e0), 256'(1));
        check("abort70_no_start", 256'(nst4 - s0), 256'(0));
        check("abort70_busy", 256'(busy4), 256'(0));
        check("abort70_block_clr", 256'(blk4), 256'(0));
        kloaded[0] = 1'b0; kstore[0] = '0;
        do_frame(0, 8'h00, b2, {128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h0}, 1'b0,
                 core_fn(b2, {128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h0}, 1'b0));

        // abort during WAIT; the late core_done must be ignored
        lat = 60; cur = 0; s0 = nst4; e0 = ner4;
        cs_set(0, 1'b0);
        send_bits({8'h80, 248'h0}, 8);
        send_bits({b1, 128'h0}, 128);
        send_bits(K128L, 128);
        repeat (10) @(posedge clk);
        #1;
        check("wabort_started", 256'(nst4 - s0), 256'(1));
        cs4_n = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        check("wabort_err", 256'(ner4 - e0), 256'(1));
        check("wabort_one_start", 256'(nst4 - s0), 256'(1));
        check("wabort_idle", 256'(busy4), 256'(0));
        check("wabort_miso", 256'(miso4), 256'(0));
        check("wabort_clr", 256'({blk4, key4}), 256'(0));
        kloaded[0] = 1'b0; kstore[0] = '0;
        lat = 20;

        // done coinciding with start is ignored; the real done is used
        zero_inj = 1'b1;
        do_frame(0, 8'h00, b1, K128L, 1'b0, core_fn(b1, K128L, 1'b0));
        zero_inj = 1'b0;

        // randomized frames against the frame-level model
        for (int i = 0; i < 4; i++) begin
            d = i % 2;
            cmd = {1'($urandom), 1'($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) == 0) ? 6'($urandom_range(1, 63)) : 6'h0};
            blk = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (d == 0) key[127:0] = '0;
            err = (|cmd[5:0]) || (cmd[6] && !(RETAIN && kloaded[d]));
            ekey = cmd[6] ? kstore[d] : key;
            do_frame(d, cmd, blk, key, err, core_fn(blk, ekey, cmd[7]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
